// File: rtl/d_mem_arbiter.sv
// Data-memory arbiter: sequences 128b refill reads and buffered word writes onto one
// memory port, with read-after-write ordering. Optional write-starvation guard: DMEM_ARB_STARVE_EN.
module d_mem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned LINE_W   = 128,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned WB_DEPTH = 4
`ifdef DMEM_ARB_STARVE_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rd_req_valid,
    input  logic [ADDR_W-1:0]             rd_req_addr,
    output logic                          rd_req_ready,
    output logic                          rd_resp_valid,
    output logic [LINE_W-1:0]             rd_resp_data,
    input  logic                          wr_req_valid,
    input  logic [ADDR_W-1:0]             wr_req_addr,
    input  logic [1:0]                    wr_req_offset,
    input  logic [WORD_W-1:0]             wr_req_data,
    output logic                          wr_req_ready,
    output logic                          mem_r_req,
    output logic                          mem_w_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [WORD_W-1:0]             mem_wr_data,
    output logic [1:0]                    mem_blockoffset,
    input  logic                          mem_comp,
    input  logic [LINE_W-1:0]             mem_rdata,
    output logic [$clog2(WB_DEPTH+1)-1:0] wb_count,
    output logic                          busy
);

    localparam int unsigned PTR_W = $clog2(WB_DEPTH);
    localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WB_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_READ_ISSUE = 2'd2,
        ST_READ_WAIT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
    logic [1:0]        wb_off_q  [WB_DEPTH];
    logic [WORD_W-1:0] wb_data_q [WB_DEPTH];
    logic [WB_DEPTH-1:0] wb_vld_q, wb_vld_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0] resp_data_q, resp_data_d;
    logic              resp_valid_q, resp_valid_d;

    logic push_s, pop_s, wb_full_s, wb_empty_s;
    logic hit_s, hazard_s, rd_grant_s, wr_grant_s, force_wr_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign wb_full_s  = (count_q == CNT_FULL);
    assign wb_empty_s = (count_q == '0);
    assign push_s     = wr_req_valid & ~wb_full_s;
    assign pop_s      = (state_q == ST_WRITE);

    // Address match of the pending read against every occupied write-buffer slot
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            hit_s = hit_s | (wb_vld_q[i] & (wb_addr_q[i] == rd_req_addr));
        end
    end

    // A same-cycle push to the read's line counts as older than the read
    assign hazard_s = rd_req_valid & (hit_s | (push_s & (wr_req_addr == rd_req_addr)));

`ifdef DMEM_ARB_STARVE_EN
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ONE = STV_W'(1);

    logic [STV_W-1:0] starve_q, starve_d;

    assign force_wr_s = (starve_q == STV_MAX) & ~wb_empty_s;

    // Consecutive read grants taken while writes are waiting
    always_comb begin
        if (wr_grant_s || wb_empty_s) begin
            starve_d = '0;
        end else if (rd_grant_s && (starve_q != STV_MAX)) begin
            starve_d = starve_q + STV_ONE;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_wr_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and arbitration grants
    always_comb begin
        state_d    = state_q;
        rd_grant_s = 1'b0;
        wr_grant_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (force_wr_s) begin
                    wr_grant_s = 1'b1;
                    state_d    = ST_WRITE;
                end else if (rd_req_valid && !hazard_s) begin
                    rd_grant_s = 1'b1;
                    state_d    = ST_READ_ISSUE;
                end else if (hazard_s || !wb_empty_s) begin
                    wr_grant_s = 1'b1;
                    state_d    = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE:      state_d = ST_IDLE;
            ST_READ_ISSUE: state_d = ST_READ_WAIT;
            ST_READ_WAIT: begin
                if (mem_comp) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ_WAIT;
                end
            end
            default:       state_d = ST_IDLE;
        endcase
    end

    // FSM memory-port outputs; everything idles at zero outside WRITE/READ_ISSUE
    always_comb begin
        mem_r_req       = 1'b0;
        mem_w_req       = 1'b0;
        mem_addr        = '0;
        mem_wr_data     = '0;
        mem_blockoffset = 2'd0;
        case (state_q)
            ST_WRITE: begin
                mem_w_req       = 1'b1;
                mem_addr        = wb_addr_q[head_q];
                mem_wr_data     = wb_data_q[head_q];
                mem_blockoffset = wb_off_q[head_q];
            end
            ST_READ_ISSUE: begin
                mem_r_req = 1'b1;
                mem_addr  = rd_addr_q;
            end
            default: begin
                mem_r_req = 1'b0;
                mem_w_req = 1'b0;
            end
        endcase
    end

    // Write-buffer pointer, occupancy and valid-bit next state
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        wb_vld_d = wb_vld_q;
        if (pop_s) begin
            head_d           = ptr_inc(head_q);
            wb_vld_d[head_q] = 1'b0;
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d           = ptr_inc(tail_q);
            wb_vld_d[tail_q] = 1'b1;
        end else begin
            tail_d = tail_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Write-buffer storage; reset discards pending writes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wb_vld_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_off_q[i]  <= 2'd0;
                wb_data_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wb_vld_q <= wb_vld_d;
            if (push_s) begin
                wb_addr_q[tail_q] <= wr_req_addr;
                wb_off_q[tail_q]  <= wr_req_offset;
                wb_data_q[tail_q] <= wr_req_data;
            end
        end
    end

    // Read address latch and refill response next state
    always_comb begin
        rd_addr_d    = rd_grant_s ? rd_req_addr : rd_addr_q;
        resp_valid_d = (state_q == ST_READ_WAIT) & mem_comp;
        if ((state_q == ST_READ_WAIT) && mem_comp) begin
            resp_data_d = mem_rdata;
        end else begin
            resp_data_d = resp_data_q;
        end
    end

    // Read-path registers; reset kills any in-flight response
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_addr_q    <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            rd_addr_q    <= rd_addr_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign rd_req_ready  = rd_grant_s;
    assign wr_req_ready  = ~wb_full_s;
    assign rd_resp_valid = resp_valid_q;
    assign rd_resp_data  = resp_data_q;
    assign wb_count      = count_q;
    assign busy          = (state_q != ST_IDLE) | ~wb_empty_s;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed self-checking bench for d_mem_arbiter with a one-cycle line memory model
// that can stall its completion.
module tb_d_mem_arbiter;

    localparam logic [127:0] LINE_3A = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] LINE_40 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         rd_req_valid;
    logic [7:0]   rd_req_addr;
    logic         rd_req_ready;
    logic         rd_resp_valid;
    logic [127:0] rd_resp_data;
    logic         wr_req_valid;
    logic [7:0]   wr_req_addr;
    logic [1:0]   wr_req_offset;
    logic [31:0]  wr_req_data;
    logic         wr_req_ready;
    logic         mem_r_req;
    logic         mem_w_req;
    logic [7:0]   mem_addr;
    logic [31:0]  mem_wr_data;
    logic [1:0]   mem_blockoffset;
    logic         mem_comp;
    logic [127:0] mem_rdata;
    logic [2:0]   wb_count;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    logic         stall;
    logic         rd_pend;
    logic [7:0]   rd_pend_addr;
    logic [127:0] mem_line [256];
    logic [7:0]   wl_addr [32];
    logic [1:0]   wl_off  [32];
    logic [31:0]  wl_data [32];
    int           wl_gnt  [32];
    int           wl_n = 0;
    int           gnt_nz = 0;
    int           resp_cnt = 0;
    logic [127:0] resp_last = 128'd0;
    logic [31:0]  wdat [4];

    d_mem_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rd_req_valid    (rd_req_valid),
        .rd_req_addr     (rd_req_addr),
        .rd_req_ready    (rd_req_ready),
        .rd_resp_valid   (rd_resp_valid),
        .rd_resp_data    (rd_resp_data),
        .wr_req_valid    (wr_req_valid),
        .wr_req_addr     (wr_req_addr),
        .wr_req_offset   (wr_req_offset),
        .wr_req_data     (wr_req_data),
        .wr_req_ready    (wr_req_ready),
        .mem_r_req       (mem_r_req),
        .mem_w_req       (mem_w_req),
        .mem_addr        (mem_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_blockoffset (mem_blockoffset),
        .mem_comp        (mem_comp),
        .mem_rdata       (mem_rdata),
        .wb_count        (wb_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Memory model, write log and grant/response monitors
    always @(posedge clk) begin
        if (rd_req_valid && rd_req_ready && (wb_count != 3'd0)) gnt_nz <= gnt_nz + 1;
        if (rd_resp_valid) begin
            resp_cnt  <= resp_cnt + 1;
            resp_last <= rd_resp_data;
        end
        if (!reset_n) begin
            mem_comp  <= 1'b0;
            mem_rdata <= 128'd0;
            rd_pend   <= 1'b0;
            rd_pend_addr <= 8'd0;
            for (int i = 0; i < 256; i++) mem_line[i] <= 128'd0;
            mem_line[8'h3A] <= LINE_3A;
            mem_line[8'h40] <= LINE_40;
        end else begin
            mem_comp <= 1'b0;
            if (mem_r_req) begin
                if (stall) begin
                    rd_pend      <= 1'b1;
                    rd_pend_addr <= mem_addr;
                end else begin
                    mem_comp  <= 1'b1;
                    mem_rdata <= mem_line[mem_addr];
                end
            end else if (rd_pend && !stall) begin
                mem_comp  <= 1'b1;
                mem_rdata <= mem_line[rd_pend_addr];
                rd_pend   <= 1'b0;
            end
            if (mem_w_req) begin
                mem_line[mem_addr][{mem_blockoffset, 5'd0} +: 32] <= mem_wr_data;
                if (wl_n < 32) begin
                    wl_addr[wl_n] <= mem_addr;
                    wl_off[wl_n]  <= mem_blockoffset;
                    wl_data[wl_n] <= mem_wr_data;
                    wl_gnt[wl_n]  <= gnt_nz;
                end
                wl_n <= wl_n + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int g0;
        int r0;
        wdat[0] = 32'h1111_0000;
        wdat[1] = 32'h2222_0001;
        wdat[2] = 32'h3333_0002;
        wdat[3] = 32'h4444_0003;
        reset_n = 1'b0; stall = 1'b0;
        rd_req_valid = 1'b0; rd_req_addr = 8'd0;
        wr_req_valid = 1'b0; wr_req_addr = 8'd0; wr_req_offset = 2'd0; wr_req_data = 32'd0;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_mem_r_req", 128'(mem_r_req), 128'd0);
        check_val("rst_mem_w_req", 128'(mem_w_req), 128'd0);
        check_val("rst_mem_addr", 128'(mem_addr), 128'd0);
        check_val("rst_rd_resp_valid", 128'(rd_resp_valid), 128'd0);
        check_val("rst_rd_resp_data", rd_resp_data, 128'd0);
        check_val("rst_wr_req_ready", 128'(wr_req_ready), 128'd1);
        check_val("rst_wb_count", 128'(wb_count), 128'd0);
        check_val("rst_busy", 128'(busy), 128'd0);
        reset_n = 1'b1;

        // single refill read of 0x3A, T -> T+1 issue -> T+3 response
        @(negedge clk);
        rd_req_valid = 1'b1; rd_req_addr = 8'h3A; #1;
        check_val("rd_ready_T", 128'(rd_req_ready), 128'd1);
        @(negedge clk);
        check_val("rd_mem_r_req_T1", 128'(mem_r_req), 128'd1);
        check_val("rd_mem_addr_T1", 128'(mem_addr), 128'h3A);
        check_val("rd_resp_valid_T1", 128'(rd_resp_valid), 128'd0);
        rd_req_valid = 1'b0;
        @(negedge clk);
        check_val("rd_mem_r_req_T2", 128'(mem_r_req), 128'd0);
        check_val("rd_resp_valid_T2", 128'(rd_resp_valid), 128'd0);
        @(negedge clk);
        check_val("rd_resp_valid_T3", 128'(rd_resp_valid), 128'd1);
        check_val("rd_resp_data_T3", rd_resp_data, LINE_3A);
        @(negedge clk);
        check_val("rd_resp_valid_T4", 128'(rd_resp_valid), 128'd0);
        check_val("rd_resp_data_hold", rd_resp_data, LINE_3A);

        // fill the write buffer behind a stalled read, then drain in order
        w0 = wl_n; r0 = resp_cnt;
        @(negedge clk);
        rd_req_valid = 1'b1; rd_req_addr = 8'h40; stall = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_req_valid = 1'b1; wr_req_addr = 8'h10 + 8'(i);
            wr_req_offset = 2'(i); wr_req_data = wdat[i];
            @(negedge clk);
        end
        check_val("wb_full_ready", 128'(wr_req_ready), 128'd0);
        check_val("wb_full_count", 128'(wb_count), 128'd4);
        wr_req_addr = 8'h77; wr_req_data = 32'hBAD0_BAD0;
        @(negedge clk);
        check_val("wb_full_no_push", 128'(wb_count), 128'd4);
        wr_req_valid = 1'b0; stall = 1'b0;
        for (int k = 0; k < 100 && (busy || wb_count != 3'd0); k++) @(negedge clk);
        check_val("wb_drain_done", 128'({busy, wb_count}), 128'd0);
        check_val("wb_drain_writes", 128'(wl_n - w0), 128'd4);
        check_val("stalled_rd_resp_cnt", 128'(resp_cnt - r0), 128'd1);
        check_val("stalled_rd_resp_data", resp_last, LINE_40);
        for (int i = 0; i < 4; i++) begin
            check_val("wb_order_addr", 128'(wl_addr[w0 + i]), 128'(8'h10 + 8'(i)));
            check_val("wb_order_off", 128'(wl_off[w0 + i]), 128'(i));
            check_val("wb_order_data", 128'(wl_data[w0 + i]), 128'(wdat[i]));
        end

        // same-cycle write and read to line 0x10: write goes first
        @(negedge clk);
        wr_req_valid = 1'b1; wr_req_addr = 8'h10; wr_req_offset = 2'd2; wr_req_data = 32'hDEAD_BEEF;
        rd_req_valid = 1'b1; rd_req_addr = 8'h10; #1;
        check_val("haz_rd_ready_held", 128'(rd_req_ready), 128'd0);
        @(negedge clk);
        wr_req_valid = 1'b0;
        check_val("haz_mem_w_req", 128'(mem_w_req), 128'd1);
        check_val("haz_mem_addr", 128'(mem_addr), 128'h10);
        check_val("haz_mem_off", 128'(mem_blockoffset), 128'd2);
        check_val("haz_mem_data", 128'(mem_wr_data), 128'hDEAD_BEEF);
        #1;
        check_val("haz_rd_ready_write", 128'(rd_req_ready), 128'd0);
        @(negedge clk);
        check_val("haz_rd_ready_after", 128'(rd_req_ready), 128'd1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        check_val("haz_mem_r_req", 128'(mem_r_req), 128'd1);
        for (int k = 0; k < 20 && !rd_resp_valid; k++) @(negedge clk);
        check_val("haz_resp_seen", 128'(rd_resp_valid), 128'd1);
        check_val("haz_resp_word2", 128'(rd_resp_data[95:64]), 128'hDEAD_BEEF);
        check_val("haz_resp_word0", 128'(rd_resp_data[31:0]), 128'(wdat[0]));

        // two writes to 0x20 queued behind back-to-back reads of 0x30
        @(negedge clk);
        w0 = wl_n; g0 = gnt_nz;
        rd_req_valid = 1'b1; rd_req_addr = 8'h30;
        @(negedge clk);
        wr_req_valid = 1'b1; wr_req_addr = 8'h20; wr_req_offset = 2'd0; wr_req_data = 32'hCAFE_0000;
        @(negedge clk);
        wr_req_offset = 2'd1; wr_req_data = 32'hCAFE_0001;
        @(negedge clk);
        wr_req_valid = 1'b0;
        for (int k = 0; k < 400 && !((gnt_nz - g0 >= 8) && mem_r_req); k++) @(negedge clk);
        check_val("stv_grants_reached", 128'(gnt_nz - g0 >= 8), 128'd1);
`ifdef DMEM_ARB_STARVE_EN
        check_val("stv_forced_write", 128'(wl_n - w0 >= 1), 128'd1);
        check_val("stv_write_after_4", 128'(wl_gnt[w0] - g0), 128'd4);
`else
        check_val("stv_no_write", 128'(wl_n - w0), 128'd0);
`endif
        rd_req_valid = 1'b0;
        for (int k = 0; k < 100 && (busy || wb_count != 3'd0); k++) @(negedge clk);
        check_val("stv_drain_done", 128'({busy, wb_count}), 128'd0);
        check_val("stv_write_count", 128'(wl_n - w0), 128'd2);
        check_val("stv_w0_addr", 128'(wl_addr[w0]), 128'h20);
        check_val("stv_w0_data", 128'(wl_data[w0]), 128'hCAFE_0000);
        check_val("stv_w1_off", 128'(wl_off[w0 + 1]), 128'd1);
        check_val("stv_w1_data", 128'(wl_data[w0 + 1]), 128'hCAFE_0001);

        // reset while a read waits on memory and three writes are buffered
        @(negedge clk);
        stall = 1'b1; rd_req_valid = 1'b1; rd_req_addr = 8'h40;
        @(negedge clk);
        rd_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_req_valid = 1'b1; wr_req_addr = 8'h60 + 8'(i);
            wr_req_offset = 2'(i); wr_req_data = wdat[i];
            @(negedge clk);
        end
        wr_req_valid = 1'b0;
        check_val("rr_wb_count_pre", 128'(wb_count), 128'd3);
        check_val("rr_busy_pre", 128'(busy), 128'd1);
        reset_n = 1'b0;
        @(negedge clk);
        r0 = resp_cnt; w0 = wl_n;
        reset_n = 1'b1; stall = 1'b0;
        check_val("rr_wb_count", 128'(wb_count), 128'd0);
        check_val("rr_busy", 128'(busy), 128'd0);
        check_val("rr_wr_ready", 128'(wr_req_ready), 128'd1);
        repeat (10) @(negedge clk);
        check_val("rr_no_resp", 128'(resp_cnt - r0), 128'd0);
        check_val("rr_no_write", 128'(wl_n - w0), 128'd0);
        check_val("rr_idle", 128'(busy), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
